// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper motion generator and coil sequencer.
package stepper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        DONE
    } gen_state_t;

    localparam int unsigned RAMP_STEP_DEF = 100;

    // Coil sequencer phases, full-step one-hot drive order A-B-C-D.
    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C,
        PH_D
    } coil_phase_t;

    function automatic logic [3:0] coil_drive(input coil_phase_t ph);
        logic [3:0] drv;
        drv = 4'b0001;
        case (ph)
            PH_A: drv = 4'b0001;
            PH_B: drv = 4'b0010;
            PH_C: drv = 4'b0100;
            PH_D: drv = 4'b1000;
            default: drv = 4'b0001;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/stepper_step_gen_step_timer.sv
// Loadable down-counter: ticks for one cycle at zero and reloads with the next interval minus one.
module step_timer #(
    parameter int unsigned PER_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    input  logic             en,
    input  logic [PER_W-1:0] reload_val,
    output logic             tick
);

    logic [PER_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= reload_val;
            end else begin
                cnt <= cnt - PER_W'(1);
            end
        end
    end

endmodule

// File: rtl/stepper_step_gen.sv
// Trapezoidal step-strobe generator with position tracking and controlled-stop abort.
module stepper_step_gen
    import stepper_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PER_W     = 20,
    parameter int unsigned RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir_in,
    input  logic [CNT_W-1:0] steps_in,
    input  logic [PER_W-1:0] per_start,
    input  logic [PER_W-1:0] per_min,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    localparam logic [PER_W:0] RAMP = (PER_W+1)'(RAMP_STEP);

    gen_state_t       state, state_n;
    logic [CNT_W-1:0] rem, rem_n, rc, rc_n, pos_n;
    logic [PER_W-1:0] cur, cur_n, ps_r, ps_n, pm_r, pm_n;
    logic             dir_n;
    logic [PER_W-1:0] ps_c, pm_c, cur_up, cur_dn, diff;
    logic [PER_W:0]   sum;
    logic             moving, tick, load;
    logic [PER_W-1:0] load_val;

    assign moving = (state == ACCEL) || (state == CRUISE) || (state == DECEL);

    step_timer #(.PER_W(PER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .en         (moving),
        .reload_val (cur_n - PER_W'(1)),
        .tick       (tick)
    );

    // Zero periods act as 1; the cruise period never exceeds the start period.
    always_comb begin
        ps_c = (per_start == '0) ? PER_W'(1) : per_start;
        pm_c = (per_min == '0) ? PER_W'(1) : per_min;
        if (pm_c > ps_c) begin
            pm_c = ps_c;
        end
    end

    always_comb begin
        sum    = {1'b0, cur} + RAMP;
        cur_up = (sum > {1'b0, ps_r}) ? ps_r : sum[PER_W-1:0];
        diff   = cur - pm_r;
        cur_dn = ({1'b0, diff} > RAMP) ? (cur - RAMP[PER_W-1:0]) : pm_r;
    end

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        rc_n     = rc;
        cur_n    = cur;
        ps_n     = ps_r;
        pm_n     = pm_r;
        dir_n    = dir;
        pos_n    = pos;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (steps_in != '0) begin
                        rem_n    = steps_in;
                        dir_n    = dir_in;
                        ps_n     = ps_c;
                        pm_n     = pm_c;
                        cur_n    = ps_c;
                        rc_n     = '0;
                        load     = 1'b1;
                        load_val = ps_c - PER_W'(1);
                        state_n  = (pm_c == ps_c) ? CRUISE : ACCEL;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (tick) begin
                    pos_n = dir ? (pos + CNT_W'(1)) : (pos - CNT_W'(1));
                    rem_n = rem - CNT_W'(1);
                    if (rem_n == '0) begin
                        state_n = DONE;
                    end else if ((state != DECEL) && (rem_n <= rc)) begin
                        state_n = DECEL;
                        cur_n   = cur_up;
                    end else if (state == DECEL) begin
                        cur_n = cur_up;
                    end else if (state == ACCEL) begin
                        cur_n = cur_dn;
                        if (cur_dn < cur) begin
                            rc_n = rc + CNT_W'(1);
                        end
                        if (cur_dn == pm_r) begin
                            state_n = CRUISE;
                        end
                    end
                end
                // Abort shortens the remaining count so the usual decel rule takes over.
                if (abort) begin
                    if ({1'b0, rem_n} > ({1'b0, rc_n} + (CNT_W+1)'(1))) begin
                        rem_n = rc_n + CNT_W'(1);
                    end
                    if (rem_n == '0) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            rc    <= '0;
            cur   <= '0;
            ps_r  <= '0;
            pm_r  <= '0;
            dir   <= 1'b0;
            pos   <= '0;
            step  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            rc    <= rc_n;
            cur   <= cur_n;
            ps_r  <= ps_n;
            pm_r  <= pm_n;
            dir   <= dir_n;
            pos   <= pos_n;
            step  <= moving && tick;
            busy  <= (state_n == ACCEL) || (state_n == CRUISE) || (state_n == DECEL);
            done  <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_stepper_step_gen.sv
// Randomized self-checking bench for stepper_step_gen against a profile-level reference model.
module tb_stepper_step_gen;

    localparam int CNT_W = 16;
    localparam int PER_W = 20;
    localparam int R     = 2;

    logic             clk = 1'b0;
    logic             rst, start, dir_in, abort;
    logic [CNT_W-1:0] steps_in;
    logic [PER_W-1:0] per_start, per_min;
    logic             step, dir, busy, done;
    logic [CNT_W-1:0] pos;

    int tests = 0;
    int fails = 0;
    int exp_ivl[$];
    logic [CNT_W-1:0] pos_m = '0;

    stepper_step_gen #(.CNT_W(CNT_W), .PER_W(PER_W), .RAMP_STEP(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir_in    (dir_in),
        .steps_in  (steps_in),
        .per_start (per_start),
        .per_min   (per_min),
        .abort     (abort),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe intervals of one move, derived step by step from the profile rules.
    task automatic model(input int ps_i, input int pm_i, input int n, input int abk);
        int ps, pm, cur, rc, rem, ph, k, nc;
        bit pend;
        exp_ivl.delete();
        ps = (ps_i == 0) ? 1 : ps_i;
        pm = (pm_i == 0) ? 1 : pm_i;
        if (pm > ps) pm = ps;
        cur = ps; rc = 0; rem = n; k = 0; pend = 0;
        ph = (pm == ps) ? 1 : 0;
        while (rem > 0) begin
            exp_ivl.push_back(cur);
            k++;
            rem--;
            if (rem == 0) break;
            if (ph != 2 && rem <= rc) begin
                ph = 2;
                cur = (cur + R > ps) ? ps : cur + R;
            end else if (ph == 2) begin
                cur = (cur + R > ps) ? ps : cur + R;
            end else if (ph == 0) begin
                nc = (cur - R > pm) ? cur - R : pm;
                if (nc < cur) rc++;
                cur = nc;
                if (cur == pm) ph = 1;
            end
            if ((k == abk && cur > 1) || (pend && k == abk + 1)) begin
                if (rem > rc + 1) rem = rc + 1;
                pend = 0;
            end else if (k == abk) begin
                pend = 1;
            end
        end
    endtask

    task automatic run_move(input int ps, input int pm, input int n, input bit d, input int abk);
        int t, last, ns, busy_bad, dir_bad, done_t, exp_t;
        bit eb;
        model(ps, pm, n, abk);
        exp_t = 0;
        foreach (exp_ivl[i]) exp_t += exp_ivl[i];
        per_start = PER_W'(ps);
        per_min   = PER_W'(pm);
        steps_in  = CNT_W'(n);
        dir_in    = d;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0; last = 0; ns = 0; busy_bad = 0; dir_bad = 0; done_t = -1;
        while (done_t < 0 && t < 4000) begin
            if (step) begin
                ns++;
                if (ns <= exp_ivl.size()) check("ivl", t - last, exp_ivl[ns-1]);
                last = t;
                if (dir !== d) dir_bad++;
            end
            eb = (n > 0) && !done;
            if (busy !== eb) busy_bad++;
            if (done) done_t = t;
            abort = step && (ns == abk);
            if (done_t < 0) begin
                @(posedge clk); #1;
                t++;
            end
        end
        abort = 1'b0;
        check("nstrobe", ns, exp_ivl.size());
        check("done_t", done_t, exp_t);
        check("busy", busy_bad, 0);
        check("dir", dir_bad, 0);
        pos_m = d ? pos_m + CNT_W'(exp_ivl.size()) : pos_m - CNT_W'(exp_ivl.size());
        check("pos", pos, pos_m);
        @(posedge clk); #1;
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int ns, t, ps, pm, n, abk;
        bit d;
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir_in = 1'b0;
        steps_in = '0; per_start = '0; per_min = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {step, dir, busy, done}, 0);
        check("rst_pos", pos, 0);
        rst = 1'b0;

        run_move(10, 2, 4, 1'b1, 0);
        run_move(10, 6, 10, 1'b0, 0);
        run_move(10, 6, 10, 1'b0, 4);
        run_move(7, 3, 0, 1'b1, 0);

        // Reset in the middle of cruise, with an ignored start while busy.
        per_start = 10; per_min = 6; steps_in = 10; dir_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ns = 0; t = 0;
        while (ns < 4 && t < 500) begin
            if (step) ns++;
            if (step && ns == 2) begin
                start = 1'b1; dir_in = 1'b1; steps_in = 1;
                @(posedge clk); #1;
                t++;
                start = 1'b0;
                check("start_ign_dir", dir, 0);
                check("start_ign_busy", busy, 1);
            end else begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("reach_cruise", ns, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out", {step, dir, busy, done}, 0);
        check("midrst_pos", pos, 0);
        pos_m = '0;
        ns = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (step || busy || done) ns++;
        end
        check("post_rst_quiet", ns, 0);

        run_move(0, 0, 3, 1'b1, 0);
        run_move(5, 9, 6, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            ps  = $urandom_range(0, 20);
            pm  = $urandom_range(0, 20);
            n   = $urandom_range(0, 12);
            d   = 1'($urandom_range(0, 1));
            abk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (n > 0) ? n : 1) : 0;
            run_move(ps, pm, n, d, abk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
